// File: rtl/cm_pkg.sv
// Shared encodings and default sizes for the LUT-tile config loader.
package cm_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ENABLE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    WAIT   = S_WAIT,
    SETUP  = S_SETUP,
    ENABLE = S_ENABLE,
    HOLD   = S_HOLD,
    DONE   = S_DONE
  } state_e;

  localparam int WORDS_DEF = 24;
  localparam int WIDTH_DEF = 32;
  localparam int IDX_W     = $clog2(WORDS_DEF);
  // Pulse counter covers EN_CYCLES up to 4.
  localparam int PCNT_W    = 2;
endpackage

// File: rtl/config_loader_if.sv
// Handshake and latch-bank bus between the tile controller and config_loader.
interface config_loader_if #(
  parameter int WORDS = 24,
  parameter int WIDTH = 32
);
  logic             io_start;
  logic             io_abort;
  logic             io_in_valid;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_d_out;
  logic [WORDS-1:0] io_configs_en;
  logic             io_busy;
  logic             io_done;

  modport master (
    output io_start, io_abort, io_in_valid, io_in_bits,
    input  io_in_ready, io_d_out, io_configs_en, io_busy, io_done
  );

  modport slave (
    input  io_start, io_abort, io_in_valid, io_in_bits,
    output io_in_ready, io_d_out, io_configs_en, io_busy, io_done
  );
endinterface

// File: rtl/config_en_decoder.sv
// Gated index-to-one-hot decoder for the latch-bank enable vector.
module config_en_decoder #(
  parameter int WORDS = 24,
  parameter int IW    = 5
) (
  input  logic [IW-1:0]    idx_i,
  input  logic             en_i,
  output logic [WORDS-1:0] onehot_o
);
  for (genvar g = 0; g < WORDS; g++) begin : g_dec
    assign onehot_o[g] = en_i & (idx_i == IW'(g));
  end
endmodule

// File: rtl/config_loader.sv
// Streams config words into the latch bank: present data, pulse one enable,
// hold data, repeat for every latch group.
module config_loader
  import cm_pkg::*;
#(
  parameter int WORDS     = WORDS_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int EN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  config_loader_if.slave   bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PCNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WORDS-1:0]  en_q, en_d;
  logic              en_gate;

  // Enables decode from the next state so the registered vector is glitch-free.
  assign en_gate = (state_d == ENABLE);

  config_en_decoder #(.WORDS(WORDS), .IW(IW)) u_dec (
    .idx_i    (idx_d),
    .en_i     (en_gate),
    .onehot_o (en_d)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: if (bus.io_start) begin
        idx_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (bus.io_in_valid) begin
        dout_d  = bus.io_in_bits;
        state_d = SETUP;
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ENABLE;
      end
      ENABLE: begin
        if (cnt_q == PCNT_W'(EN_CYCLES - 1)) state_d = HOLD;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      HOLD: begin
        if (idx_q == IW'(WORDS - 1)) state_d = DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort beats everything, including a same-cycle WAIT handshake.
    if (state_q != IDLE && bus.io_abort) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      dout_d  = dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
    end
  end

  assign bus.io_in_ready   = (state_q == WAIT);
  assign bus.io_busy       = (state_q == WAIT) || (state_q == SETUP) ||
                             (state_q == ENABLE) || (state_q == HOLD);
  assign bus.io_done       = (state_q == DONE);
  assign bus.io_d_out      = dout_q;
  assign bus.io_configs_en = en_q;
endmodule

// File: tb/tb_config_loader.sv
// Drives two loaders (EN_CYCLES=1 and 3) with shared stimulus and checks each
// against a timeline model built from the word-period timing rules.
module tb_config_loader;
  localparam int W  = 24;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, valid;
  logic [DW-1:0] bits;

  config_loader_if #(.WORDS(W), .WIDTH(DW)) bif0 ();
  config_loader_if #(.WORDS(W), .WIDTH(DW)) bif1 ();

  assign bif0.io_start = start;  assign bif1.io_start = start;
  assign bif0.io_abort = abort;  assign bif1.io_abort = abort;
  assign bif0.io_in_valid = valid; assign bif1.io_in_valid = valid;
  assign bif0.io_in_bits  = bits;  assign bif1.io_in_bits  = bits;

  config_loader #(.WORDS(W), .WIDTH(DW), .EN_CYCLES(1)) dut0 (.clk(clk), .reset(rst), .bus(bif0));
  config_loader #(.WORDS(W), .WIDTH(DW), .EN_CYCLES(3)) dut1 (.clk(clk), .reset(rst), .bus(bif1));

  logic [1:0][W-1:0]  oen;
  logic [1:0][DW-1:0] od;
  logic [1:0]         ordy, obsy, odn;
  assign oen[0] = bif0.io_configs_en; assign oen[1] = bif1.io_configs_en;
  assign od[0]  = bif0.io_d_out;      assign od[1]  = bif1.io_d_out;
  assign ordy   = {bif1.io_in_ready, bif0.io_in_ready};
  assign obsy   = {bif1.io_busy,     bif0.io_busy};
  assign odn    = {bif1.io_done,     bif0.io_done};

  // Model: act = load in progress, acc = current word accepted at cycle t.
  bit            act[2], acc[2];
  int            t[2], idx[2], dcyc[2];
  logic [DW-1:0] dexp[2];
  logic [W-1:0]  xen[2];
  logic [DW-1:0] xd[2];
  logic          xrdy[2], xbsy[2], xdn[2];
  int            cyc = 0, checks = 0, errors = 0;

  function automatic int enc(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      int r;
      r = cyc - t[i];
      if (rst) begin
        act[i] = 0; acc[i] = 0; idx[i] = 0; dexp[i] = '0; dcyc[i] = -1;
      end else if (act[i] && abort) begin
        act[i] = 0; acc[i] = 0; idx[i] = 0;
      end else if (act[i]) begin
        if (!acc[i]) begin
          if (valid) begin acc[i] = 1; t[i] = cyc; dexp[i] = bits; end
        end else if (r == 2 + enc(i)) begin
          acc[i] = 0;
          if (idx[i] == W - 1) begin act[i] = 0; dcyc[i] = cyc + 1; end
          else idx[i]++;
        end
      end else if (start && cyc != dcyc[i]) begin
        act[i] = 1; acc[i] = 0; idx[i] = 0;
      end
    end
    @(posedge clk); #1; cyc++;
    for (int i = 0; i < 2; i++) begin
      int r;
      r = cyc - t[i];
      xen[i] = '0; xd[i] = dexp[i]; xdn[i] = (cyc == dcyc[i]);
      xbsy[i] = act[i]; xrdy[i] = act[i] && !acc[i];
      if (act[i] && acc[i] && r >= 2 && r <= 1 + enc(i)) xen[i] = W'(1) << idx[i];
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; abort = 0; valid = 0; bits = '0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (n == 2) rst = 0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (oen[i] !== xen[i] || od[i] !== xd[i] || ordy[i] !== xrdy[i] || obsy[i] !== xbsy[i] || odn[i] !== xdn[i] || !$onehot0(oen[i])) begin
          errors++;
          $display("FAIL reset inst%0d cyc %0d: got en=%h d=%h rdy=%b busy=%b done=%b want en=%h d=%h rdy=%b busy=%b done=%b", i, cyc, oen[i], od[i], ordy[i], obsy[i], odn[i], xen[i], xd[i], xrdy[i], xbsy[i], xdn[i]);
        end
      end
    end
  endtask

  task automatic test_full_load();
    int s, d0, d1;
    s = cyc; d0 = -1; d1 = -1;
    start = 1; valid = 1; bits = 32'hA000_0000;
    for (int n = 0; n < 300; n++) begin
      tick();
      start = 0;
      bits = 32'hA000_0000 + DW'(idx[0]);
      if (odn[0] && d0 < 0) d0 = cyc - s;
      if (odn[1] && d1 < 0) d1 = cyc - s;
      if ((cyc - s) >= 3 && (cyc - s) <= 95 && ((cyc - s - 3) % 4) == 0) begin
        checks++;
        if (oen[0] !== (W'(1) << ((cyc - s - 3) / 4))) begin
          errors++;
          $display("FAIL full_load_en cyc %0d: got %h want bit %0d", cyc - s, oen[0], (cyc - s - 3) / 4);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (oen[i] !== xen[i] || od[i] !== xd[i] || ordy[i] !== xrdy[i] || obsy[i] !== xbsy[i] || odn[i] !== xdn[i] || !$onehot0(oen[i])) begin
          errors++;
          $display("FAIL full_load inst%0d cyc %0d: got en=%h d=%h rdy=%b busy=%b done=%b want en=%h d=%h rdy=%b busy=%b done=%b", i, cyc, oen[i], od[i], ordy[i], obsy[i], odn[i], xen[i], xd[i], xrdy[i], xbsy[i], xdn[i]);
        end
      end
      if (!act[0] && !act[1] && cyc > dcyc[0] && cyc > dcyc[1]) break;
    end
    checks++;
    if (d0 !== 97 || d1 !== 145) begin
      errors++;
      $display("FAIL full_load_done: got cycles %0d/%0d want 97/145", d0, d1);
    end
  endtask

  task automatic test_backpressure();
    int s; logic [DW-1:0] w6;
    s = cyc; w6 = '0;
    start = 1; valid = 1; bits = $urandom;
    for (int n = 0; n < 300; n++) begin
      tick();
      start = 0;
      valid = !((cyc - s) >= 29 && (cyc - s) <= 33);
      bits = $urandom;
      if (cyc - s == 25) w6 = bits;
      if (cyc - s == 31 || cyc - s == 36) begin
        checks++;
        if ((cyc - s == 31 && (od[0] !== w6 || oen[0] !== '0 || ordy[0] !== 1'b1)) ||
            (cyc - s == 36 && oen[0] !== (W'(1) << 7))) begin
          errors++;
          $display("FAIL backpressure cyc %0d: got en=%h d=%h want w6=%h", cyc - s, oen[0], od[0], w6);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (oen[i] !== xen[i] || od[i] !== xd[i] || ordy[i] !== xrdy[i] || obsy[i] !== xbsy[i] || odn[i] !== xdn[i] || !$onehot0(oen[i])) begin
          errors++;
          $display("FAIL backpressure inst%0d cyc %0d: got en=%h d=%h rdy=%b busy=%b done=%b want en=%h d=%h rdy=%b busy=%b done=%b", i, cyc, oen[i], od[i], ordy[i], obsy[i], odn[i], xen[i], xd[i], xrdy[i], xbsy[i], xdn[i]);
        end
      end
      if (!act[0] && !act[1] && cyc > dcyc[0] && cyc > dcyc[1]) break;
    end
    checks++;
    if (act[0] || act[1]) begin
      errors++;
      $display("FAIL backpressure_timeout: load still active %b%b want idle", act[1], act[0]);
    end
  endtask

  task automatic test_abort();
    int s, s2;
    s = cyc; s2 = -100;
    start = 1; valid = 1; bits = $urandom;
    for (int n = 0; n < 80; n++) begin
      tick();
      start = 0; abort = 0; bits = $urandom;
      if (cyc - s == 43) abort = 1;
      if (cyc - s == 60) begin start = 1; s2 = cyc; end
      if (cyc - s2 == 12) abort = 1;
      if (cyc - s == 44 || cyc - s2 == 3) begin
        checks++;
        if ((cyc - s == 44 && (obsy[0] !== 1'b0 || oen[0] !== '0 || odn[0] !== 1'b0)) ||
            (cyc - s2 == 3 && oen[0] !== W'(1))) begin
          errors++;
          $display("FAIL abort cyc %0d: got en=%h busy=%b done=%b", cyc - s, oen[0], obsy[0], odn[0]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (oen[i] !== xen[i] || od[i] !== xd[i] || ordy[i] !== xrdy[i] || obsy[i] !== xbsy[i] || odn[i] !== xdn[i] || !$onehot0(oen[i])) begin
          errors++;
          $display("FAIL abort inst%0d cyc %0d: got en=%h d=%h rdy=%b busy=%b done=%b want en=%h d=%h rdy=%b busy=%b done=%b", i, cyc, oen[i], od[i], ordy[i], obsy[i], odn[i], xen[i], xd[i], xrdy[i], xbsy[i], xdn[i]);
        end
      end
    end
    abort = 0;
  endtask

  task automatic test_midload_reset();
    int s;
    s = cyc;
    start = 1; valid = 1; bits = $urandom;
    for (int n = 0; n < 90; n++) begin
      tick();
      start = 0; rst = 0; abort = 0; bits = $urandom;
      if (cyc - s == 62) rst = 1;
      if (cyc - s == 63) start = 1;
      if (cyc - s == 85) abort = 1;
      if (cyc - s == 63 || cyc - s == 64) begin
        checks++;
        if ((cyc - s == 63 && (od[0] !== '0 || oen[0] !== '0 || obsy[0] !== 1'b0 || ordy[0] !== 1'b0)) ||
            (cyc - s == 64 && ordy[0] !== 1'b1)) begin
          errors++;
          $display("FAIL midload_reset cyc %0d: got d=%h en=%h busy=%b rdy=%b", cyc - s, od[0], oen[0], obsy[0], ordy[0]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (oen[i] !== xen[i] || od[i] !== xd[i] || ordy[i] !== xrdy[i] || obsy[i] !== xbsy[i] || odn[i] !== xdn[i] || !$onehot0(oen[i])) begin
          errors++;
          $display("FAIL midload_reset inst%0d cyc %0d: got en=%h d=%h rdy=%b busy=%b done=%b want en=%h d=%h rdy=%b busy=%b done=%b", i, cyc, oen[i], od[i], ordy[i], obsy[i], odn[i], xen[i], xd[i], xrdy[i], xbsy[i], xdn[i]);
        end
      end
    end
    abort = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      valid = ($urandom_range(0, 3) != 0);
      bits  = $urandom;
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 199) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (oen[i] !== xen[i] || od[i] !== xd[i] || ordy[i] !== xrdy[i] || obsy[i] !== xbsy[i] || odn[i] !== xdn[i] || !$onehot0(oen[i])) begin
          errors++;
          $display("FAIL random inst%0d cyc %0d: got en=%h d=%h rdy=%b busy=%b done=%b want en=%h d=%h rdy=%b busy=%b done=%b", i, cyc, oen[i], od[i], ordy[i], obsy[i], odn[i], xen[i], xd[i], xrdy[i], xbsy[i], xdn[i]);
        end
      end
    end
    rst = 0; start = 0; abort = 0; valid = 0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    tick();
    test_backpressure();
    tick();
    test_abort();
    tick();
    test_midload_reset();
    tick();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
